// File: rtl/sobel_rd_stream.sv
// Read-side front end for the Sobel AFU: issues sequential cache-line reads on
// CCI channel 0, buffers in-order responses in a FIFO and streams them out.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; counters hold their last values
// ISSUE | issuing line reads while credits and channel allow
// DRAIN | all reads issued; waiting for the last line to be consumed
// DONE  | one-cycle completion pulse, back to IDLE
module sobel_rd_stream #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_lines,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_req_valid,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic [15:0]           rd_req_mdata,
  input  logic                  c0TxAlmFull,
  input  logic                  rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  err_unexpected
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [CNT_WIDTH-1:0]  r_req_cnt;
  logic [CNT_WIDTH-1:0]  r_rsp_cnt;
  logic [CNT_WIDTH-1:0]  r_out_cnt;

  logic                  r_req_valid;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [15:0]           r_req_mdata;
  logic                  r_err;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_fifo_cnt;
  logic [PW:0]           w_fifo_cnt_nxt;
  logic                  r_out_valid;

  logic                  w_start_acc;
  logic [CNT_WIDTH-1:0]  w_in_flight;
  logic [CNT_WIDTH:0]    w_credit_used;
  logic                  w_credit_ok;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_unexp;
  logic                  w_pop;
  logic [CNT_WIDTH-1:0]  w_out_cnt_nxt;
  logic                  w_busy;
  logic                  w_done;

  assign w_start_acc   = (r_state == S_IDLE) && start;
  assign w_in_flight   = r_req_cnt - r_rsp_cnt;
  // Lines already requested but not yet consumed must fit in the FIFO.
  assign w_credit_used = {1'b0, w_in_flight} + (CNT_WIDTH+1)'(r_fifo_cnt);
  assign w_credit_ok   = w_credit_used < (CNT_WIDTH+1)'(FIFO_DEPTH);
  assign w_issue       = (r_state == S_ISSUE) && !c0TxAlmFull &&
                         (r_req_cnt < r_num) && w_credit_ok;
  assign w_push        = rd_rsp_valid && (w_in_flight != '0);
  assign w_unexp       = rd_rsp_valid && (w_in_flight == '0);
  assign w_pop         = r_out_valid && out_ready;
  assign w_out_cnt_nxt = r_out_cnt + CNT_WIDTH'(w_pop);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state; DRAIN looks at the pop of this cycle so done follows
  // the final pop directly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (num_lines == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_req_cnt == r_num) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_cnt_nxt == r_num) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_ISSUE: w_busy = 1'b1;
      S_DRAIN: w_busy = 1'b1;
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  assign busy = w_busy;
  assign done = w_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base <= '0;
      r_num  <= '0;
    end else if (w_start_acc) begin
      r_base <= base_addr;
      r_num  <= num_lines;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
      r_out_cnt <= '0;
    end else if (w_start_acc) begin
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_issue) begin
        r_req_cnt <= r_req_cnt + 1'b1;
      end
      if (w_push) begin
        r_rsp_cnt <= r_rsp_cnt + 1'b1;
      end
      r_out_cnt <= w_out_cnt_nxt;
    end
  end

  // Address wraps silently at 2^ADDR_WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_mdata <= '0;
    end else begin
      r_req_valid <= w_issue;
      if (w_issue) begin
        r_req_addr  <= r_base + ADDR_WIDTH'(r_req_cnt);
        r_req_mdata <= 16'(r_req_cnt);
      end
    end
  end

  assign rd_req_valid = r_req_valid;
  assign rd_req_addr  = r_req_addr;
  assign rd_req_mdata = r_req_mdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_unexp) begin
      r_err <= 1'b1;
    end
  end

  assign err_unexpected = r_err;

  always_comb begin
    w_fifo_cnt_nxt = r_fifo_cnt;
    case ({w_push, w_pop})
      2'b10:   w_fifo_cnt_nxt = r_fifo_cnt + 1'b1;
      2'b01:   w_fifo_cnt_nxt = r_fifo_cnt - 1'b1;
      default: w_fifo_cnt_nxt = r_fifo_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_fifo_cnt  <= w_fifo_cnt_nxt;
      r_out_valid <= (w_fifo_cnt_nxt != '0);
    end
  end

  // Storage carries no reset; out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rd_rsp_data;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_valid ? r_mem[r_rd_ptr] : '0;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_push && !w_pop && (r_fifo_cnt == (PW+1)'(FIFO_DEPTH))));

endmodule

// File: tb/tb_sobel_rd_stream.sv
// Directed bench for sobel_rd_stream: a responder model answers reads, and
// request/output monitors compare against queues filled at job start.
module tb_sobel_rd_stream;

  localparam int AW    = 42;
  localparam int DW    = 512;
  localparam int DEPTH = 64;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_lines = '0;
  logic          busy, done, rd_req_valid, out_valid, err_unexpected;
  logic [AW-1:0] rd_req_addr;
  logic [15:0]   rd_req_mdata;
  logic          c0TxAlmFull = 1'b0;
  logic          rd_rsp_valid = 1'b0;
  logic [DW-1:0] rd_rsp_data = '0;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;

  sobel_rd_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .busy(busy), .done(done), .rd_req_valid(rd_req_valid),
    .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .c0TxAlmFull(c0TxAlmFull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_req[$];
  logic [DW-1:0] exp_data[$];
  int            pend_due[$];
  logic [AW-1:0] pend_addr[$];

  int rsp_delay = 3;
  int req_seen = 0, rsp_sent = 0, done_seen = 0, alm_cycles = 0;
  int req_first = -1, req_last = -1;
  bit alm_prev = 1'b0, done_prev = 1'b0;

  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
    logic [31:0] w;
    w = a[31:0];
    return {8{w ^ 32'h5A5A_0F0F, ~w}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: answers each observed request rsp_delay cycles later, in order.
  always @(negedge clk) begin
    if (!reset_n) begin
      pend_due.delete();
      pend_addr.delete();
      rd_rsp_valid = 1'b0;
    end else begin
      if (rd_req_valid) begin
        pend_due.push_back(cyc + rsp_delay);
        pend_addr.push_back(rd_req_addr);
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = line_of(pend_addr.pop_front());
        void'(pend_due.pop_front());
        rsp_sent++;
      end else begin
        rd_rsp_valid = 1'b0;
      end
    end
  end

  // Request monitor
  always @(negedge clk) begin
    if (!reset_n) begin
      alm_prev = 1'b0;
    end else begin
      if (alm_prev) begin
        alm_cycles++;
        chk("req_during_almfull", 64'(rd_req_valid), 64'd0);
      end
      if (rd_req_valid) begin
        if (exp_req.size() == 0) begin
          chk("unexpected_req_addr", 64'(rd_req_addr), 64'h0BAD);
        end else begin
          chk("req_addr", 64'(rd_req_addr), 64'(exp_req.pop_front()));
          chk("req_mdata", 64'(rd_req_mdata), 64'(16'(req_seen)));
        end
        req_seen++;
        if (req_first < 0) req_first = cyc;
        req_last = cyc;
      end
      alm_prev = c0TxAlmFull;
    end
  end

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (!reset_n) begin
      done_prev = 1'b0;
    end else begin
      if (done) begin
        done_seen++;
        chk("busy_with_done", 64'(busy), 64'd1);
      end
      if (done_prev && !done) chk("busy_falls_with_done", 64'(busy), 64'd0);
      done_prev = done;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %h expected no data", out_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_data.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_data: got %h expected %h", out_data, e);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_req.push_back(base + AW'(i));
      exp_data.push_back(line_of(base + AW'(i)));
    end
    req_seen  = 0;
    rsp_sent  = 0;
    req_first = -1;
    req_last  = -1;
    base_addr = base;
    num_lines = CW'(n);
    start     = 1'b1;
    step(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit got;
    got = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, bound);
    end
    step(1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_req_valid"}, 64'(rd_req_valid), 64'd0);
    chk({name, "_req_addr"}, 64'(rd_req_addr), 64'd0);
    chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_out_data"}, 64'(|out_data), 64'd0);
    chk({name, "_err"}, 64'(err_unexpected), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int d0;
    #1 reset_n = 1'b0;
    #2 chk_all_zero("reset");
    step(2);
    reset_n = 1'b1;
    step(2);

    // Basic 4-line job, 3-cycle response latency; a start while busy is ignored.
    rsp_delay = 3;
    out_ready = 1'b1;
    d0 = done_seen;
    start_job(42'h1000, 4);
    base_addr = 42'h9000;
    num_lines = 2;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done("job1", 60);
    step(3);
    chk("job1_done_once", 64'(done_seen - d0), 64'd1);
    chk("job1_reqs", 64'(req_seen), 64'd4);
    chk("job1_consecutive", 64'(req_last - req_first), 64'd3);
    chk("job1_drained", 64'(exp_data.size()), 64'd0);

    // Credit limit: consumer stalled, immediate responses.
    rsp_delay = 0;
    out_ready = 1'b0;
    start_job(42'h4000, 100);
    step(120);
    chk("credit_reqs", 64'(req_seen), 64'd64);
    chk("credit_req_low", 64'(rd_req_valid), 64'd0);
    chk("credit_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_done("job2", 400);
    chk("job2_reqs", 64'(req_seen), 64'd100);
    chk("job2_drained", 64'(exp_data.size()), 64'd0);

    // Almost-full backpressure for 10 cycles mid-issue.
    rsp_delay = 2;
    start_job(42'h8000, 30);
    for (int k = 0; k < 50 && req_seen < 5; k++) step(1);
    chk("alm_reached_issue", 64'(req_seen >= 5), 64'd1);
    d0 = alm_cycles;
    c0TxAlmFull = 1'b1;
    step(10);
    c0TxAlmFull = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("alm_resume", 64'(rd_req_valid), 64'd1);
    step(1);
    wait_done("job3", 200);
    chk("alm_blocked_cycles", 64'(alm_cycles - d0), 64'd10);
    chk("job3_reqs", 64'(req_seen), 64'd30);
    chk("job3_drained", 64'(exp_data.size()), 64'd0);

    // Zero-length job, with a start pulse during its DONE cycle.
    d0 = done_seen;
    req_seen = 0;
    base_addr = 42'h3000;
    num_lines = 0;
    start = 1'b1;
    step(1);
    num_lines = 5;
    @(negedge clk);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd1);
    step(1);
    start = 1'b0;
    @(negedge clk);
    chk("zero_done_low", 64'(done), 64'd0);
    chk("zero_busy_low", 64'(busy), 64'd0);
    step(6);
    chk("zero_no_reqs", 64'(req_seen), 64'd0);
    chk("zero_done_once", 64'(done_seen - d0), 64'd1);

    // Response with nothing outstanding.
    pend_due.push_back(cyc);
    pend_addr.push_back(42'h123);
    step(1);
    chk("unexp_err", 64'(err_unexpected), 64'd1);
    step(3);
    chk("unexp_err_sticky", 64'(err_unexpected), 64'd1);
    chk("unexp_no_out", 64'(out_valid), 64'd0);
    reset_n = 1'b0;
    #1 chk("unexp_reset_clears", 64'(err_unexpected), 64'd0);
    step(1);
    reset_n = 1'b1;
    step(1);

    // Abort mid-job with requests in flight and lines buffered.
    rsp_delay = 4;
    out_ready = 1'b0;
    start_job(42'h6000, 20);
    for (int k = 0; k < 50 && rsp_sent < 3; k++) step(1);
    chk("abort_buffered", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1 chk_all_zero("abort");
    exp_req.delete();
    exp_data.delete();
    step(1);
    reset_n = 1'b1;
    step(1);
    pend_due.push_back(cyc);
    pend_addr.push_back(42'h6007);
    step(1);
    chk("stale_rsp_err", 64'(err_unexpected), 64'd1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    rsp_delay = 1;
    out_ready = 1'b1;
    start_job(42'h7000, 3);
    wait_done("job_after_abort", 60);
    chk("restart_reqs", 64'(req_seen), 64'd3);
    chk("restart_drained", 64'(exp_data.size()), 64'd0);
    chk("restart_err", 64'(err_unexpected), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
